ppu_writeback: RTL and testbench



---
 rtl/ppu_writeback_if.sv | 26 ++
 rtl/ppu_writeback.sv | 143 ++++++++++++++
 tb/tb_ppu_writeback.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_writeback_if.sv
// Psum stream and word-write port of the PPU write-back packer.
// Both channels are valid/ready: a transfer happens on a rising clock edge where valid && ready;
// the sender holds valid and its payload stable until that edge and never waits for ready to raise valid.
interface ppu_writeback_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32
);
    logic                 psum_valid;
    logic                 psum_ready;
    logic [DATA_BITS-1:0] psum_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;

    modport master (
        input  psum_valid, psum_data, wr_ready,
        output psum_ready, wr_valid, wr_addr, wr_data, wr_strb
    );

    modport slave (
        output psum_valid, psum_data, wr_ready,
        input  psum_ready, wr_valid, wr_addr, wr_data, wr_strb
    );
endinterface

// File: rtl/ppu_writeback.sv
// Sequences psums into the PPU, captures its 8-bit results and packs four per
// 32-bit word toward the global buffer; the last partial word is strobed per filled lane.
module ppu_writeback #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_pool,
    input  logic                 cfg_relu,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [CNT_BITS-1:0]  cfg_num_out,
    ppu_writeback_if.master      bus,
    output logic [DATA_BITS-1:0] ppu_data_in,
    output logic                 ppu_maxpool_init,
    output logic                 ppu_maxpool_en,
    output logic                 ppu_relu_sel,
    output logic                 ppu_relu_en,
    input  logic [7:0]           ppu_data_out,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic                 pool_q;
    logic                 relu_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [CNT_BITS+1:0]  in_rem;
    logic [CNT_BITS-1:0]  out_rem;
    logic [1:0]           elem;
    logic [1:0]           lane;
    logic                 pool_done;
    logic [23:0]          pack;

    logic                 wr_pending;
    logic                 accept;
    logic                 capture;
    logic                 last_capture;
    logic [3:0]           part_strb;

    assign wr_pending     = bus.wr_valid && !bus.wr_ready;
    assign bus.psum_ready = (state == S_RUN) && (in_rem != '0) && !wr_pending;
    assign accept         = bus.psum_valid && bus.psum_ready;
    // Pool mode captures the cycle after the 4th element; non-pool captures on the accept itself.
    assign capture        = pool_q ? pool_done : accept;
    assign last_capture   = capture && (out_rem == CNT_BITS'(1));
    assign part_strb      = (4'b0001 << lane) - 4'b0001;

    assign ppu_data_in      = bus.psum_data;
    assign ppu_maxpool_init = accept && pool_q && (elem == 2'd0);
    assign ppu_maxpool_en   = accept && pool_q && (elem != 2'd0);
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign ppu_relu_sel     = busy && pool_q;
    assign ppu_relu_en      = busy && relu_q;
    assign state_dbg        = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pool_q       <= 1'b0;
            relu_q       <= 1'b0;
            addr_q       <= '0;
            in_rem       <= '0;
            out_rem      <= '0;
            elem         <= 2'd0;
            lane         <= 2'd0;
            pool_done    <= 1'b0;
            pack         <= '0;
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.wr_strb  <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pool_q  <= cfg_pool;
                        relu_q  <= cfg_relu;
                        addr_q  <= cfg_base_addr;
                        in_rem  <= cfg_pool ? {cfg_num_out, 2'b00} : {2'b00, cfg_num_out};
                        out_rem <= cfg_num_out;
                        elem    <= 2'd0;
                        lane    <= 2'd0;
                        pack    <= '0;
                        state   <= (cfg_num_out == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_capture) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Leave once nothing is buffered and the output register is free or draining now.
                    if (lane == 2'd0 && (!bus.wr_valid || bus.wr_ready)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                in_rem <= in_rem - (CNT_BITS+2)'(1);
                if (pool_q) elem <= elem + 2'd1;
            end
            pool_done <= accept && pool_q && (elem == 2'd3);

            if (bus.wr_valid && bus.wr_ready) bus.wr_valid <= 1'b0;

            if (capture) begin
                out_rem <= out_rem - CNT_BITS'(1);
                lane    <= lane + 2'd1;
                case (lane)
                    2'd0: pack[7:0]   <= ppu_data_out;
                    2'd1: pack[15:8]  <= ppu_data_out;
                    2'd2: pack[23:16] <= ppu_data_out;
                    default: begin
                        bus.wr_valid <= 1'b1;
                        bus.wr_data  <= {ppu_data_out, pack};
                        bus.wr_strb  <= 4'b1111;
                        bus.wr_addr  <= addr_q;
                        addr_q       <= addr_q + ADDR_BITS'(4);
                        pack         <= '0;
                    end
                endcase
            end else if (state == S_FLUSH && !bus.wr_valid && lane != 2'd0) begin
                bus.wr_valid <= 1'b1;
                bus.wr_data  <= {8'h00, pack};
                bus.wr_strb  <= part_strb;
                bus.wr_addr  <= addr_q;
                addr_q       <= addr_q + ADDR_BITS'(4);
                lane         <= 2'd0;
                pack         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_writeback.sv
// Randomized scoreboard bench for ppu_writeback with a small behavioural PPU attached.
module tb_ppu_writeback;
    localparam int DB = 32;
    localparam int AB = 32;
    localparam int CB = 16;
    localparam int W  = 68;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          start = 1'b0;
    logic          cfg_pool = 1'b0, cfg_relu = 1'b0;
    logic [AB-1:0] cfg_base_addr = '0;
    logic [CB-1:0] cfg_num_out = '0;
    logic [DB-1:0] ppu_data_in;
    logic          ppu_maxpool_init, ppu_maxpool_en, ppu_relu_sel, ppu_relu_en;
    logic [7:0]    ppu_data_out;
    logic          busy, done;
    logic [1:0]    state_dbg;

    ppu_writeback_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    ppu_writeback #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pool(cfg_pool), .cfg_relu(cfg_relu),
        .cfg_base_addr(cfg_base_addr), .cfg_num_out(cfg_num_out), .bus(bus),
        .ppu_data_in(ppu_data_in), .ppu_maxpool_init(ppu_maxpool_init),
        .ppu_maxpool_en(ppu_maxpool_en), .ppu_relu_sel(ppu_relu_sel), .ppu_relu_en(ppu_relu_en),
        .ppu_data_out(ppu_data_out), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- PPU model ----------------
    logic signed [31:0] pool_max = 0;
    always @(posedge clk) begin
        if (ppu_maxpool_init) pool_max <= ppu_data_in;
        else if (ppu_maxpool_en && $signed(ppu_data_in) > pool_max) pool_max <= ppu_data_in;
    end
    function automatic logic [7:0] act(input logic [31:0] v, input logic relu);
        return (relu && v[31]) ? 8'h00 : v[7:0];
    endfunction
    assign ppu_data_out = ppu_relu_sel ? act(pool_max, ppu_relu_en) : act(ppu_data_in, ppu_relu_en);

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [31:0]  stim_q[$];
    int n_vec = 0, n_err = 0;
    bit job_pool = 0, job_relu = 0;
    int acc_cnt = 0, init_cnt = 0, en_cnt = 0, wr_cnt = 0, last_wr_cyc = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: each output is the (pooled) psum after optional ReLU, low byte kept.
    task automatic model(input bit pool, input bit relu, input logic [31:0] base, input int num);
        logic [7:0]  outs[$];
        logic [31:0] data;
        logic [3:0]  strb;
        logic signed [31:0] v;
        for (int i = 0; i < num; i++) begin
            if (pool) begin
                v = stim_q[4*i];
                for (int j = 1; j < 4; j++)
                    if ($signed(stim_q[4*i+j]) > v) v = stim_q[4*i+j];
            end else begin
                v = stim_q[i];
            end
            outs.push_back((relu && v < 0) ? 8'h00 : v[7:0]);
        end
        for (int w = 0; 4*w < num; w++) begin
            data = '0;
            strb = '0;
            for (int l = 0; l < 4; l++)
                if (4*w + l < num) begin
                    data[8*l +: 8] = outs[4*w + l];
                    strb[l] = 1'b1;
                end
            exp_q.push_back({base + 32'(4*w), data, strb});
        end
    endtask

    // ---------------- write-port ready driver ----------------
    int rdy_mode = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: bus.wr_ready = ($urandom_range(0, 2) != 0);
            2: if (bus.wr_valid && hold_cnt < 5) begin
                   bus.wr_ready = 1'b0;
                   hold_cnt++;
               end else bus.wr_ready = 1'b1;
            default: bus.wr_ready = 1'b1;
        endcase
    end

    // ---------------- monitor ----------------
    bit          hold_prev = 0;
    logic [W-1:0] prev_fields = '0;
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 0;
        end else begin
            if (bus.psum_valid && bus.psum_ready) begin
                acc_cnt++;
                init_cnt += int'(ppu_maxpool_init);
                en_cnt   += int'(ppu_maxpool_en);
                check("data_pass", ppu_data_in, bus.psum_data);
                check("relu_sel", ppu_relu_sel, job_pool);
                check("relu_en", ppu_relu_en, job_relu);
            end
            if (hold_prev) begin
                check("hold_valid", bus.wr_valid, 1'b1);
                check("hold_fields", {bus.wr_addr, bus.wr_data, bus.wr_strb}, prev_fields);
            end
            if (bus.wr_valid && !bus.wr_ready) check("ready_gate", bus.psum_ready, 1'b0);
            if (bus.wr_valid && bus.wr_ready) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got %h expected none", {bus.wr_addr, bus.wr_data, bus.wr_strb});
                end else begin
                    check("write", {bus.wr_addr, bus.wr_data, bus.wr_strb}, exp_q.pop_front());
                end
            end
            hold_prev   = bus.wr_valid && !bus.wr_ready;
            prev_fields = {bus.wr_addr, bus.wr_data, bus.wr_strb};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gen_ps(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++)
            case ($urandom_range(0, 2))
                0: stim_q.push_back($urandom);
                1: stim_q.push_back(32'($urandom_range(0, 255)));
                default: stim_q.push_back(32'(-int'($urandom_range(1, 300))));
            endcase
    endtask

    task automatic pulse_start(input bit pool, input bit relu, input logic [31:0] base, input int num);
        @(posedge clk); #1;
        cfg_pool = pool; cfg_relu = relu; cfg_base_addr = base; cfg_num_out = CB'(num);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_pool = 1'($urandom); cfg_relu = 1'($urandom);
        cfg_base_addr = $urandom; cfg_num_out = CB'($urandom);
    endtask

    task automatic feed(input int n, input bit gaps);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            int t;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.psum_valid = 1'b0;
                bus.psum_data = $urandom;
                @(posedge clk); #1;
            end
            bus.psum_valid = 1'b1;
            bus.psum_data = stim_q[i];
            for (t = 0; t < 200; t++) begin
                @(negedge clk);
                if (bus.psum_ready) break;
            end
            if (t == 200) begin
                n_vec++; n_err++;
                $display("FAIL psum_timeout: got no psum_ready required ready within 200 cycles");
                bus.psum_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            bus.psum_valid = 1'b0;
        end
    endtask

    task automatic run_job(input bit pool, input bit relu, input logic [31:0] base, input int num,
                           input int mode, input bit ign, input bit lat);
        int n_in, t;
        n_in = pool ? 4*num : num;
        job_pool = pool; job_relu = relu;
        acc_cnt = 0; init_cnt = 0; en_cnt = 0; wr_cnt = 0;
        rdy_mode = mode; hold_cnt = 0;
        model(pool, relu, base, num);
        pulse_start(pool, relu, base, num);
        @(negedge clk);
        check("busy_rise", busy, 1'b1);
        if (num == 0) begin
            check("zero_done", done, 1'b1);
            check("zero_ready", bus.psum_ready, 1'b0);
            check("zero_wvalid", bus.wr_valid, 1'b0);
            @(negedge clk);
            check("zero_idle", {busy, done}, 2'b00);
            return;
        end
        fork
            feed(n_in, !lat);
            if (ign) begin
                repeat (3) @(posedge clk);
                #1;
                cfg_num_out = CB'($urandom_range(1, 3)); cfg_base_addr = $urandom; cfg_pool = ~pool;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        if (lat) begin
            @(negedge clk);
            check("lat_first", bus.wr_valid, !pool);
            if (pool) begin
                @(negedge clk);
                check("lat_pool", bus.wr_valid, 1'b1);
            end
        end
        for (t = 0; t < 500; t++) begin
            if (done) break;
            @(negedge clk);
        end
        if (t == 500) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done required done within 500 cycles");
            exp_q.delete();
            return;
        end
        check("done_lat", 32'(cyc - last_wr_cyc), 32'd1);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("word_count", 32'(wr_cnt), 32'((num + 3) / 4));
        check("accepts", 32'(acc_cnt), 32'(n_in));
        check("init_count", 32'(init_cnt), pool ? 32'(num) : 32'd0);
        check("en_count", 32'(en_cnt), pool ? 32'(3*num) : 32'd0);
        @(negedge clk);
        check("done_pulse", {busy, done}, 2'b00);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.psum_valid = 1'b0;
        bus.psum_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", {bus.psum_ready, ppu_maxpool_init, ppu_maxpool_en, ppu_relu_sel, ppu_relu_en,
                             bus.wr_valid, busy, done, bus.wr_addr, bus.wr_data, bus.wr_strb}, '0);
        rst = 1'b1;

        stim_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_job(0, 0, 32'h100, 4, 0, 0, 1);
        gen_ps(8);
        run_job(1, 1, 32'h200, 2, 0, 0, 0);
        gen_ps(16);
        run_job(1, 0, 32'h300, 4, 0, 0, 1);
        gen_ps(8);
        run_job(0, 1, 32'h400, 8, 2, 0, 0);
        run_job(0, 0, 32'h500, 0, 0, 0, 0);

        // Abort a job after two captures; nothing may be written.
        gen_ps(2);
        job_pool = 0; job_relu = 0; acc_cnt = 0; wr_cnt = 0; rdy_mode = 0;
        pulse_start(0, 0, 32'h600, 8);
        feed(2, 0);
        rst = 1'b0;
        #1;
        check("midjob_reset", {bus.psum_ready, ppu_maxpool_init, ppu_maxpool_en, ppu_relu_sel, ppu_relu_en,
                               bus.wr_valid, busy, done, bus.wr_addr, bus.wr_data, bus.wr_strb}, '0);
        check("midjob_writes", 32'(wr_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        gen_ps(5);
        run_job(0, 0, 32'h600, 5, 0, 0, 0);

        gen_ps(12);
        run_job(0, 1, 32'h700, 12, 1, 1, 0);

        for (int k = 0; k < 14; k++) begin
            bit p, r, ig;
            int num;
            p = 1'($urandom);
            r = 1'($urandom);
            num = $urandom_range(1, 20);
            ig = ((p ? 4*num : num) >= 6) && ($urandom_range(0, 1) == 1);
            gen_ps(p ? 4*num : num);
            run_job(p, r, {$urandom_range(0, 32'hFFFF), 2'b00}, num, $urandom_range(0, 1), ig, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule
